// File: rtl/image_ram_scheduler_pkg.sv
// Shared decoder constants and scheduler state encodings.
package image_ram_scheduler_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int TABLE_SIZE   = 64;
  localparam int PIXEL_WIDTH  = 8;

  typedef enum logic {
    ST_IDLE        = 1'b0,
    ST_WRITE_BLOCK = 1'b1
  } sched_state_t;

endpackage

// File: rtl/image_ram_scheduler_read_valid_pipe.sv
// Delays read grants by the RAM read latency and presents ram_q as read data
// in the cycle the delayed grant emerges.
module read_valid_pipe #(
  parameter int READ_LATENCY = 1,
  parameter int PIXEL_WIDTH  = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   grant,
  input  logic [PIXEL_WIDTH-1:0] ram_q,
  output logic                   valid,
  output logic [PIXEL_WIDTH-1:0] data
);

  logic [READ_LATENCY-1:0] stages;

  // shift grants along; reset drops any reads in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stages <= '0;
    end else begin
      stages <= (stages << 1) | READ_LATENCY'(grant);
    end
  end

  assign valid = stages[READ_LATENCY-1];
  assign data  = valid ? ram_q : '0;

endmodule

// File: rtl/image_ram_scheduler.sv
// Arbitrates the single-port image RAM between the block writer and a pixel
// reader. A table start reserves the RAM for the full block; idle cycles go to
// the reader, with a bounded run so pending tables are never starved.
module image_ram_scheduler #(
  parameter int IMAGE_RAM_ADDRESS_WIDTH = 17,
  parameter int PIXEL_WIDTH             = image_ram_scheduler_pkg::PIXEL_WIDTH,
  parameter int TABLE_SIZE              = image_ram_scheduler_pkg::TABLE_SIZE,
  parameter int READ_LATENCY            = 1,
  parameter int MAX_READ_RUN            = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               table_valid,
  output logic                               table_accept,
  output logic                               gen_start,
  input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] wr_address,
  input  logic [PIXEL_WIDTH-1:0]             wr_data,
  input  logic                               wr_CE,
  input  logic                               wr_WE,
  input  logic                               image_generated,
  input  logic                               rd_req,
  input  logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] rd_address,
  output logic                               rd_grant,
  output logic                               rd_valid,
  output logic [PIXEL_WIDTH-1:0]             rd_data,
  output logic [IMAGE_RAM_ADDRESS_WIDTH-1:0] ram_address,
  output logic [PIXEL_WIDTH-1:0]             ram_data,
  output logic                               ram_CE,
  output logic                               ram_WE,
  input  logic [PIXEL_WIDTH-1:0]             ram_q,
  output logic                               frame_done,
  output logic                               protocol_error
);

  import image_ram_scheduler_pkg::*;

  localparam int              WC_W    = $clog2(TABLE_SIZE + 1);
  localparam logic [WC_W-1:0] WC_LAST = WC_W'(TABLE_SIZE - 1);
  localparam logic [7:0]      RUN_MAX = 8'(MAX_READ_RUN);

  sched_state_t    state, state_nxt;
  logic [WC_W-1:0] write_count;
  logic [7:0]      read_run;
  logic            start;

  assign gen_start    = start;
  assign table_accept = start;

  // state, block write counter, reader run length and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ST_IDLE;
      write_count    <= '0;
      read_run       <= '0;
      frame_done     <= 1'b0;
      protocol_error <= 1'b0;
    end else begin
      state <= state_nxt;

      // write_count tracks WRITE_BLOCK cycles; the block ends on its last write
      if (start) begin
        write_count <= '0;
      end else if (state == ST_WRITE_BLOCK) begin
        write_count <= write_count + 1'b1;
      end

      // run length only matters while a table is waiting behind the reader
      if (start || (state == ST_IDLE && !table_valid)) begin
        read_run <= '0;
      end else if (rd_grant && table_valid && read_run != RUN_MAX) begin
        read_run <= read_run + 8'd1;
      end

      frame_done <= image_generated;

      if (state == ST_IDLE && wr_CE) begin
        protocol_error <= 1'b1;
      end
    end
  end

  // next state, grant decision and RAM port mux
  always_comb begin
    state_nxt   = state;
    start       = 1'b0;
    rd_grant    = 1'b0;
    ram_address = '0;
    ram_data    = '0;
    ram_CE      = 1'b0;
    ram_WE      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (table_valid && (!rd_req || read_run == RUN_MAX)) begin
          start     = 1'b1;
          state_nxt = ST_WRITE_BLOCK;
        end else if (rd_req) begin
          rd_grant = 1'b1;
        end
        if (rd_grant) begin
          ram_address = rd_address;
          ram_CE      = 1'b1;
        end else if (wr_CE) begin
          // stray writer access is flagged but still reaches the RAM
          ram_address = wr_address;
          ram_data    = wr_data;
          ram_CE      = 1'b1;
          ram_WE      = wr_WE;
        end
      end
      ST_WRITE_BLOCK: begin
        if (wr_CE) begin
          ram_address = wr_address;
          ram_data    = wr_data;
          ram_CE      = 1'b1;
          ram_WE      = wr_WE;
        end
        if (write_count == WC_LAST) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  read_valid_pipe #(
    .READ_LATENCY(READ_LATENCY),
    .PIXEL_WIDTH (PIXEL_WIDTH)
  ) u_read_valid_pipe (
    .clk  (clk),
    .rst  (rst),
    .grant(rd_grant),
    .ram_q(ram_q),
    .valid(rd_valid),
    .data (rd_data)
  );

endmodule

// File: tb/tb_image_ram_scheduler.sv
// Bench for image_ram_scheduler: RAM and block-writer models, read scoreboard
// and cycle-indexed scenario checks.
module tb_image_ram_scheduler;

  localparam int AW  = 17;
  localparam int PW  = 8;
  localparam int TS  = 64;
  localparam int RL  = 2;
  localparam int MRR = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          table_valid, table_accept, gen_start;
  logic [AW-1:0] wr_address;
  logic [PW-1:0] wr_data;
  logic          wr_CE, wr_WE;
  logic          image_generated;
  logic          rd_req;
  logic [AW-1:0] rd_address;
  logic          rd_grant, rd_valid;
  logic [PW-1:0] rd_data;
  logic [AW-1:0] ram_address;
  logic [PW-1:0] ram_data;
  logic          ram_CE, ram_WE;
  logic [PW-1:0] ram_q;
  logic          frame_done, protocol_error;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  image_ram_scheduler #(
    .IMAGE_RAM_ADDRESS_WIDTH(AW),
    .PIXEL_WIDTH            (PW),
    .TABLE_SIZE             (TS),
    .READ_LATENCY           (RL),
    .MAX_READ_RUN           (MRR)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .table_valid    (table_valid),
    .table_accept   (table_accept),
    .gen_start      (gen_start),
    .wr_address     (wr_address),
    .wr_data        (wr_data),
    .wr_CE          (wr_CE),
    .wr_WE          (wr_WE),
    .image_generated(image_generated),
    .rd_req         (rd_req),
    .rd_address     (rd_address),
    .rd_grant       (rd_grant),
    .rd_valid       (rd_valid),
    .rd_data        (rd_data),
    .ram_address    (ram_address),
    .ram_data       (ram_data),
    .ram_CE         (ram_CE),
    .ram_WE         (ram_WE),
    .ram_q          (ram_q),
    .frame_done     (frame_done),
    .protocol_error (protocol_error)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // preloaded RAM contents for the read region
  function automatic logic [PW-1:0] pre(input logic [AW-1:0] a);
    return 8'((a * 7) + 3);
  endfunction

  // RAM model: RL-cycle read latency, counts write strobes
  logic [PW-1:0] q_pipe [0:RL-1];
  int            ram_wr_cnt = 0;
  always @(posedge clk) begin
    q_pipe[0] <= pre(ram_address);
    for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
    if (ram_CE && ram_WE) ram_wr_cnt <= ram_wr_cnt + 1;
  end
  assign ram_q = q_pipe[RL-1];

  // block writer model: TS writes starting the cycle after gen_start
  int   wr_left;
  logic ce_force;
  always @(posedge clk or negedge rst) begin
    if (!rst) wr_left <= 0;
    else if (gen_start) wr_left <= TS;
    else if (wr_left > 0) wr_left <= wr_left - 1;
  end
  assign wr_CE      = (wr_left > 0) || ce_force;
  assign wr_WE      = wr_CE;
  assign wr_address = AW'(512 + TS - wr_left);
  assign wr_data    = 8'(TS - wr_left) ^ 8'hA5;

  // read scoreboard: expected data pushed at grant, popped at rd_valid
  logic [PW-1:0] exp_q [$];
  always @(negedge clk) begin
    if (!rst) begin
      exp_q.delete();
    end else begin
      if (rd_valid) begin
        check_eq("rd_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check_eq("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
      if (rd_grant) exp_q.push_back(pre(rd_address));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int  wc0;
    logic accepted;
    logic gs_seen;

    table_valid = 0; rd_req = 0; rd_address = '0; ce_force = 0; image_generated = 0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_gen_start", 32'(gen_start), 0);
    check_eq("rst_table_accept", 32'(table_accept), 0);
    check_eq("rst_rd_valid", 32'(rd_valid), 0);
    check_eq("rst_rd_data", 32'(rd_data), 0);
    check_eq("rst_frame_done", 32'(frame_done), 0);
    check_eq("rst_protocol_error", 32'(protocol_error), 0);
    @(negedge clk);
    rst = 1;

    // A: idle reader, table at 10, reader waits through the block
    accepted = 0;
    wc0 = ram_wr_cnt;
    for (int rel = 0; rel < 80; rel++) begin
      @(posedge clk); #1;
      table_valid = (rel >= 10) && !accepted;
      rd_req      = (rel >= 40 && rel <= 76);
      rd_address  = AW'(rel);
      @(negedge clk);
      if (gen_start) accepted = 1;
      check_eq("A_gen_start", 32'(gen_start), 32'(rel == 10));
      check_eq("A_table_accept", 32'(table_accept), 32'(rel == 10));
      check_eq("A_rd_grant", 32'(rd_grant), 32'(rel >= 75 && rel <= 76));
      if (rel >= 11 && rel <= 74) begin
        check_eq("A_ram_we", 32'(ram_WE), 32'(wr_WE));
        check_eq("A_ram_data", 32'(ram_data), 32'(wr_data));
        check_eq("A_ram_addr", 32'(ram_address), 32'(wr_address));
      end
    end
    check_eq("A_write_count", 32'(ram_wr_cnt - wc0), 32'(TS));

    // B: steady reader with a pending table; bounded run then block
    accepted = 0;
    for (int rel = 0; rel < 90; rel++) begin
      @(posedge clk); #1;
      table_valid = !accepted;
      rd_req      = (rel <= 85);
      rd_address  = AW'(rel);
      @(negedge clk);
      if (gen_start) accepted = 1;
      check_eq("B_gen_start", 32'(gen_start), 32'(rel == MRR));
      check_eq("B_rd_grant", 32'(rd_grant), 32'(rel < MRR || (rel >= MRR + TS + 1 && rel <= 85)));
    end
    table_valid = 0;

    // C: back-to-back reads of 5, 6, 7 with two-cycle latency
    for (int rel = 0; rel < 6; rel++) begin
      @(posedge clk); #1;
      rd_req     = (rel < 3);
      rd_address = AW'(5 + rel);
      @(negedge clk);
      check_eq("C_rd_valid", 32'(rd_valid), 32'(rel >= 2 && rel <= 4));
      if (rel >= 2 && rel <= 4) check_eq("C_rd_data", 32'(rd_data), 32'(pre(AW'(rel + 3))));
    end
    rd_req = 0;

    // D: stray write in IDLE and frame_done pulse
    for (int rel = 0; rel < 6; rel++) begin
      @(posedge clk); #1;
      ce_force        = (rel == 1);
      image_generated = (rel == 3);
      @(negedge clk);
      check_eq("D_protocol_error", 32'(protocol_error), 32'(rel >= 2));
      check_eq("D_forwarded_we", 32'(ram_WE), 32'(rel == 1));
      check_eq("D_frame_done", 32'(frame_done), 32'(rel == 4));
    end
    ce_force = 0; image_generated = 0;

    // E: reset at write_count 30, then a clean block
    gs_seen = 0;
    for (int i = 0; i < 10 && !gs_seen; i++) begin
      @(posedge clk); #1;
      table_valid = 1;
      @(negedge clk);
      if (gen_start) gs_seen = 1;
    end
    check_eq("E_first_start", 32'(gs_seen), 1);
    repeat (31) begin
      @(posedge clk); #1;
      table_valid = 0;
    end
    check_eq("E_pre_ram_ce", 32'(ram_CE), 1);
    #2 rst = 0;
    #1;
    check_eq("E_rst_ram_ce", 32'(ram_CE), 0);
    check_eq("E_rst_gen_start", 32'(gen_start), 0);
    check_eq("E_rst_rd_valid", 32'(rd_valid), 0);
    check_eq("E_rst_rd_data", 32'(rd_data), 0);
    check_eq("E_rst_frame_done", 32'(frame_done), 0);
    check_eq("E_rst_protocol_error", 32'(protocol_error), 0);
    @(negedge clk);
    rst = 1;
    accepted = 0;
    wc0 = ram_wr_cnt;
    for (int rel = 0; rel < 70; rel++) begin
      @(posedge clk); #1;
      table_valid = (rel >= 1) && !accepted;
      @(negedge clk);
      if (gen_start) accepted = 1;
      check_eq("E_gen_start", 32'(gen_start), 32'(rel == 1));
    end
    check_eq("E_write_count", 32'(ram_wr_cnt - wc0), 32'(TS));
    check_eq("E_protocol_error", 32'(protocol_error), 0);

    repeat (4) @(negedge clk);
    check_eq("rd_lost", 32'(exp_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
